// File: rtl/al_clk_pkg.sv
// Shared types and helpers for the alarm-clock keypad time-entry stage.
package al_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int unsigned KEY_DIGIT_MAX = 9;
  localparam int unsigned DIGITS_MAX    = 4;

  typedef struct packed {
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // 00:00 .. 23:59 in BCD
  function automatic logic bcd_time_valid(input logic [15:0] raw);
    bcd_time_t t;
    logic      hour_ok;
    t       = bcd_time_t'(raw);
    hour_ok = (t.ms_hour == 4'd2) ? (t.ls_hour <= 4'd3) : (t.ls_hour <= 4'd9);
    return (t.ms_hour <= 4'd2) && hour_ok && (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/al_clk_rise_detect.sv
// One-bit rising-edge detector; history register clears on async reset.
module al_clk_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_c_o
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_i;
  end

  assign rise_c_o = level_i & ~level_q;

endmodule

// File: rtl/al_clk_key_entry.sv
// Keypad HH:MM entry: collects BCD digits, range-checks them and issues a
// one-cycle time/alarm load strobe, with an inactivity timeout.
module al_clk_key_entry
  import al_clk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic        one_second,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        time_button,
  input  logic        alarm_button,
  output logic [15:0] key_buffer,
  output logic        load_new_time,
  output logic        load_new_alarm,
  output logic        entry_active,
  output logic [2:0]  digit_count,
  output logic        entry_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_SEC + 1);

  logic          key_rise, time_rise, alarm_rise;
  logic          digit_rise, one_button;
  state_e        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ld_time_q, ld_time_d;
  logic          ld_alarm_q, ld_alarm_d;
  logic          err_q, err_d;
  logic          active_q;

  al_clk_rise_detect u_key_rise (
    .clk(clk256), .rst(reset), .level_i(key_valid), .rise_c_o(key_rise)
  );
  al_clk_rise_detect u_time_rise (
    .clk(clk256), .rst(reset), .level_i(time_button), .rise_c_o(time_rise)
  );
  al_clk_rise_detect u_alarm_rise (
    .clk(clk256), .rst(reset), .level_i(alarm_button), .rise_c_o(alarm_rise)
  );

  assign digit_rise = key_rise && (key <= 4'(KEY_DIGIT_MAX));
  assign one_button = time_rise ^ alarm_rise;

  // Priority inside ENTRY: button rise, then digit rise, then one_second.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (digit_rise) begin
          state_d = ENTRY;
          buf_d   = {12'h000, key};
          cnt_d   = 3'd1;
          timer_d = '0;
        end
      end
      ENTRY: begin
        if (time_rise || alarm_rise) begin
          timer_d = '0;
          if (one_button && (cnt_q == 3'(DIGITS_MAX)) && bcd_time_valid(buf_q)) begin
            state_d    = LOAD;
            ld_time_d  = time_rise;
            ld_alarm_d = alarm_rise;
          end else begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end else if (digit_rise) begin
          buf_d   = {buf_q[11:0], key};
          cnt_d   = (cnt_q == 3'(DIGITS_MAX)) ? cnt_q : cnt_q + 3'd1;
          timer_d = '0;
        end else if (one_second) begin
          if (timer_q == TW'(TIMEOUT_SEC - 1)) begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      err_q      <= err_d;
      active_q   <= (state_d == ENTRY);
    end
  end

  assign key_buffer     = buf_q;
  assign load_new_time  = ld_time_q;
  assign load_new_alarm = ld_alarm_q;
  assign entry_active   = active_q;
  assign digit_count    = cnt_q;
  assign entry_error    = err_q;

endmodule

// File: tb/tb_al_clk_key_entry.sv
// Self-checking bench for al_clk_key_entry: directed scenarios plus random
// stimulus, all checked each cycle against a digit-queue reference model.
module tb_al_clk_key_entry;

  localparam int unsigned TMO = 10;

  logic        clk256 = 1'b0;
  logic        reset;
  logic        one_second;
  logic [3:0]  key;
  logic        key_valid;
  logic        time_button;
  logic        alarm_button;
  logic [15:0] key_buffer;
  logic        load_new_time;
  logic        load_new_alarm;
  logic        entry_active;
  logic [2:0]  digit_count;
  logic        entry_error;

  int n_cmp = 0;
  int n_bad = 0;

  al_clk_key_entry #(.TIMEOUT_SEC(TMO)) dut (
    .clk256(clk256), .reset(reset), .one_second(one_second), .key(key),
    .key_valid(key_valid), .time_button(time_button), .alarm_button(alarm_button),
    .key_buffer(key_buffer), .load_new_time(load_new_time),
    .load_new_alarm(load_new_alarm), .entry_active(entry_active),
    .digit_count(digit_count), .entry_error(entry_error)
  );

  always #5 clk256 = ~clk256;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the typed digits are a queue; mode 0=waiting, 1=typing, 2=loading.
  int         m_mode;
  int         m_secs;
  int         m_digits[$];
  bit         m_pkv, m_ptb, m_pab;
  bit         m_ld_t, m_ld_a, m_err;

  function automatic bit model_time_ok();
    int hh, mm;
    hh = m_digits[0] * 10 + m_digits[1];
    mm = m_digits[2] * 10 + m_digits[3];
    return (hh <= 23) && (mm <= 59);
  endfunction

  function automatic logic [15:0] model_buf();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_digits.delete();
    m_pkv = 0; m_ptb = 0; m_pab = 0;
    m_ld_t = 0; m_ld_a = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit kr, tr, ar, dig;
    kr = key_valid & ~m_pkv;
    tr = time_button & ~m_ptb;
    ar = alarm_button & ~m_pab;
    m_pkv = key_valid; m_ptb = time_button; m_pab = alarm_button;
    dig = kr && (int'(key) < 10);
    m_ld_t = 0; m_ld_a = 0; m_err = 0;
    if (m_mode == 2) begin
      m_mode = 0;
      m_digits.delete();
    end else if (m_mode == 1) begin
      if (tr || ar) begin
        if ((tr != ar) && m_digits.size() == 4 && model_time_ok()) begin
          m_mode = 2; m_ld_t = tr; m_ld_a = ar;
        end else begin
          m_mode = 0; m_err = 1; m_digits.delete();
        end
      end else if (dig) begin
        m_digits.push_back(int'(key));
        if (m_digits.size() > 4) void'(m_digits.pop_front());
        m_secs = 0;
      end else if (one_second) begin
        m_secs++;
        if (m_secs == TMO) begin
          m_mode = 0; m_secs = 0; m_digits.delete();
        end
      end
    end else if (dig) begin
      m_digits.delete();
      m_digits.push_back(int'(key));
      m_mode = 1; m_secs = 0;
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk256);
      if (reset) model_reset();
      else model_step();
      #1;
      chk("key_buffer", 32'(key_buffer), 32'(model_buf()));
      chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
      chk("entry_active", 32'(entry_active), 32'(m_mode == 1));
      chk("load_new_time", 32'(load_new_time), 32'(m_ld_t));
      chk("load_new_alarm", 32'(load_new_alarm), 32'(m_ld_a));
      chk("entry_error", 32'(entry_error), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk256);
  endtask

  task automatic press_key(input logic [3:0] k);
    key = k; key_valid = 1'b1; tick(); tick();
    key_valid = 1'b0; tick();
  endtask

  task automatic btn_down(input logic t, input logic a);
    time_button = t; alarm_button = a; tick();
  endtask

  task automatic btn_up();
    time_button = 1'b0; alarm_button = 1'b0; tick();
  endtask

  task automatic strobes(input string tag, input logic t, input logic a, input logic e);
    chk({tag, ".load_new_time"}, 32'(load_new_time), 32'(t));
    chk({tag, ".load_new_alarm"}, 32'(load_new_alarm), 32'(a));
    chk({tag, ".entry_error"}, 32'(entry_error), 32'(e));
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; key = 4'd0; key_valid = 1'b0;
    time_button = 1'b0; alarm_button = 1'b0;
    tick(); tick(); tick();
    chk("rst.key_buffer", 32'(key_buffer), 32'h0);
    chk("rst.digit_count", 32'(digit_count), 32'h0);
    chk("rst.entry_active", 32'(entry_active), 32'h0);
    strobes("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0; tick();

    // 1,2,3,4 + TIME
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    chk("t1.count", 32'(digit_count), 32'd4);
    btn_down(1'b1, 1'b0);
    chk("t1.buf", 32'(key_buffer), 32'h1234);
    strobes("t1", 1'b1, 1'b0, 1'b0);
    btn_up();
    strobes("t1.after", 1'b0, 1'b0, 1'b0);
    chk("t1.buf_clr", 32'(key_buffer), 32'h0);
    chk("t1.idle", 32'(entry_active), 32'h0);

    // 24:00 rejected, 23:59 accepted as alarm
    press_key(4'd2); press_key(4'd4); press_key(4'd0); press_key(4'd0);
    btn_down(1'b0, 1'b1);
    strobes("t2.err", 1'b0, 1'b0, 1'b1);
    btn_up();
    press_key(4'd2); press_key(4'd3); press_key(4'd5); press_key(4'd9);
    btn_down(1'b0, 1'b1);
    chk("t2.buf", 32'(key_buffer), 32'h2359);
    strobes("t2.ok", 1'b0, 1'b1, 1'b0);
    btn_up();

    // Short entry errors; five digits keep the last four
    press_key(4'd1); press_key(4'd2);
    btn_down(1'b1, 1'b0);
    strobes("t3.short", 1'b0, 1'b0, 1'b1);
    chk("t3.count_clr", 32'(digit_count), 32'h0);
    btn_up();
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4); press_key(4'd5);
    chk("t3.count_sat", 32'(digit_count), 32'd4);
    press_key(4'd11);
    chk("t3.nondigit", 32'(key_buffer), 32'h2345);
    btn_down(1'b1, 1'b0);
    chk("t3.buf", 32'(key_buffer), 32'h2345);
    strobes("t3.ok", 1'b1, 1'b0, 1'b0);
    btn_up();

    // Timeout after TMO pulses
    press_key(4'd7);
    for (int i = 0; i < int'(TMO); i++) begin
      if (i == int'(TMO) - 1) chk("t4.still_active", 32'(entry_active), 32'h1);
      one_second = 1'b1; tick(); one_second = 1'b0; tick();
    end
    chk("t4.active", 32'(entry_active), 32'h0);
    chk("t4.count", 32'(digit_count), 32'h0);
    strobes("t4", 1'b0, 1'b0, 1'b0);

    // Both buttons together
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    btn_down(1'b1, 1'b1);
    strobes("t5", 1'b0, 1'b0, 1'b1);
    btn_up();

    // Held key counts once
    key = 4'd5; key_valid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    chk("t6.count", 32'(digit_count), 32'd1);
    chk("t6.buf", 32'(key_buffer), 32'h0005);
    key_valid = 1'b0; tick();

    // Reset during LOAD
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    time_button = 1'b1;
    @(posedge clk256); #3;
    chk("t7.strobe_pre", 32'(load_new_time), 32'h1);
    reset = 1'b1; time_button = 1'b0;
    #1;
    chk("t7.strobe_rst", 32'(load_new_time), 32'h0);
    chk("t7.buf_rst", 32'(key_buffer), 32'h0);
    chk("t7.count_rst", 32'(digit_count), 32'h0);
    tick(); tick();
    reset = 1'b0; tick();

    // Random traffic: busy phase, then sparse keys so timeouts occur
    for (int seg = 0; seg < 2; seg++) begin
      for (int c = 0; c < 2500; c++) begin
        if ($urandom_range(0, (seg == 0) ? 3 : 40) == 0) key_valid = ~key_valid;
        key = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        if ($urandom_range(0, 25) == 0) time_button = ~time_button;
        if ($urandom_range(0, 25) == 0) alarm_button = ~alarm_button;
        one_second = ($urandom_range(0, (seg == 0) ? 6 : 1) == 0);
        tick();
      end
    end
    one_second = 1'b0; key_valid = 1'b0; time_button = 1'b0; alarm_button = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
